// File: rtl/audio_dac_serializer_if.sv
// Sample-write handshake between the sample-processing logic and the DAC serializer.
// The producer drives write and the sample pair; the serializer returns write_ready.
interface audio_dac_serializer_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  write;
  logic                  write_ready;
  logic [DATA_WIDTH-1:0] writedata_left;
  logic [DATA_WIDTH-1:0] writedata_right;

  modport master (
    output write,
    output writedata_left,
    output writedata_right,
    input  write_ready
  );

  modport slave (
    input  write,
    input  writedata_left,
    input  writedata_right,
    output write_ready
  );
endinterface

// File: rtl/audio_dac_serializer.sv
// Buffers stereo sample pairs and shifts them out left-justified to a WM8731 DAC,
// timed by the codec-mastered BCLK/DACLRCK, which are sampled in the CLOCK_50 domain.
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int UNDERRUN_W = 16
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  audio_dac_serializer_if.slave         bus,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [UNDERRUN_W-1:0]         underrun_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int PAIR_W = 2 * DATA_WIDTH;

  logic [1:0] bclkSync_q;
  logic       bclkPrev_q;
  logic [1:0] lrckSync_q;
  logic       lrckPrev_q;
  logic [1:0] armCnt_q, armCnt_d;
  logic       armed;
  logic       bclkFall, lrckRise, lrckFall;

  logic [PAIR_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] held_q, held_d;
  logic                  dacdat_q;
  logic [PAIR_W-1:0]     readPair;
  logic                  full, empty, push, pop, underrun;

  // Edges are ignored until the synchronizers have refilled after reset,
  // otherwise a pin already high at release would look like a rising edge.
  assign armed    = (armCnt_q == 2'd3);
  assign armCnt_d = armed ? armCnt_q : armCnt_q + 2'd1;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclkSync_q <= '0;
      bclkPrev_q <= 1'b0;
      lrckSync_q <= '0;
      lrckPrev_q <= 1'b0;
      armCnt_q   <= '0;
    end else begin
      bclkSync_q <= {bclkSync_q[0], AUD_BCLK};
      bclkPrev_q <= bclkSync_q[1];
      lrckSync_q <= {lrckSync_q[0], AUD_DACLRCK};
      lrckPrev_q <= lrckSync_q[1];
      armCnt_q   <= armCnt_d;
    end
  end

  assign bclkFall = armed &  bclkPrev_q & ~bclkSync_q[1];
  assign lrckRise = armed & ~lrckPrev_q &  lrckSync_q[1];
  assign lrckFall = armed &  lrckPrev_q & ~lrckSync_q[1];

  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign push     = bus.write & ~full;
  assign pop      = lrckRise & ~empty;
  assign underrun = lrckRise & empty;
  assign readPair = mem_q[rdPtr_q];

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_q[wrPtr_q] <= {bus.writedata_left, bus.writedata_right};
    end
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    underrun_d = underrun_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (underrun && !(&underrun_q)) begin
      underrun_d = underrun_q + UNDERRUN_W'(1);
    end
  end

  // A frame-clock load takes priority over a coincident BCLK shift so the MSB
  // is presented in the first bit slot of each half-frame.
  always_comb begin
    shift_d = shift_q;
    held_d  = held_q;
    if (lrckRise) begin
      if (empty) begin
        shift_d = '0;
        held_d  = '0;
      end else begin
        shift_d = readPair[PAIR_W-1:DATA_WIDTH];
        held_d  = readPair[DATA_WIDTH-1:0];
      end
    end else if (lrckFall) begin
      shift_d = held_q;
    end else if (bclkFall) begin
      shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      underrun_q <= '0;
      shift_q    <= '0;
      held_q     <= '0;
      dacdat_q   <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
      shift_q    <= shift_d;
      held_q     <= held_d;
      dacdat_q   <= shift_q[DATA_WIDTH-1];
    end
  end

  assign bus.write_ready = ~full;
  assign AUD_DACDAT      = dacdat_q;
  assign fifo_level      = level_q;
  assign underrun_count  = underrun_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench: a behavioural codec drives BCLK/DACLRCK, pushed pairs go to a
// scoreboard queue and are compared against the bits captured from AUD_DACDAT.
module tb_audio_dac_serializer;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [3:0]  expLevel;
    logic        expReady;
  } vec_t;

  logic        CLOCK_50;
  logic        reset;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;
  logic [3:0]  fifo_level;
  logic [15:0] underrun_count;
  logic        smallDacdat;
  logic [3:0]  smallLevel;
  logic [1:0]  smallUnderrun;

  int    compared   = 0;
  int    mismatched = 0;
  int    underrunModel = 0;
  int    smallModel    = 0;
  pair_t expQ[$];
  vec_t  vecs[8];

  audio_dac_serializer_if #(.DATA_WIDTH(24)) bus ();
  audio_dac_serializer_if #(.DATA_WIDTH(24)) bus2 ();

  audio_dac_serializer #(
    .DATA_WIDTH(24), .FIFO_DEPTH(8), .UNDERRUN_W(16)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .bus(bus),
    .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT),
    .fifo_level(fifo_level), .underrun_count(underrun_count)
  );

  // Narrow underrun counter so saturation is reachable in a few frames.
  audio_dac_serializer #(
    .DATA_WIDTH(24), .FIFO_DEPTH(8), .UNDERRUN_W(2)
  ) dutSmall (
    .CLOCK_50(CLOCK_50), .reset(reset), .bus(bus2),
    .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(smallDacdat),
    .fifo_level(smallLevel), .underrun_count(smallUnderrun)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r);
    pair_t np;
    bus.write           = 1'b1;
    bus.writedata_left  = l;
    bus.writedata_right = r;
    @(negedge CLOCK_50);
    bus.write = 1'b0;
    if (expQ.size() < 8) begin
      np.l = l;
      np.r = r;
      expQ.push_back(np);
    end
  endtask

  // One 8-cycle BCLK period: falling edge (and any LRCK change) at c=0,
  // rising at c=4, DACDAT sampled at c=6 once the 4-cycle latency has passed.
  task automatic bclkSlot(input logic lr, input bit pushNow, input logic [23:0] pl,
                          input logic [23:0] pr, output logic bo);
    bo = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        AUD_BCLK    = 1'b0;
        AUD_DACLRCK = lr;
      end
      if (c == 4) AUD_BCLK = 1'b1;
      if (c == 6) bo = AUD_DACDAT;
      if (pushNow && c == 2) begin
        bus.write           = 1'b1;
        bus.writedata_left  = pl;
        bus.writedata_right = pr;
      end
      if (pushNow && c == 3) bus.write = 1'b0;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic playFrame(input bit pushAtRise, input logic [23:0] pl,
                           input logic [23:0] pr, input string tag,
                           output logic [63:0] bits);
    pair_t exp;
    pair_t np;
    logic  b;
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
    end else begin
      exp.l = '0;
      exp.r = '0;
      underrunModel++;
    end
    if (smallModel < 3) smallModel++;
    if (pushAtRise) begin
      np.l = pl;
      np.r = pr;
      expQ.push_back(np);
    end
    for (int s = 0; s < 64; s++) begin
      bclkSlot(s < 32, pushAtRise && s == 0, pl, pr, b);
      bits[63-s] = b;
    end
    checkOutput({tag, " left"},       64'(bits[63:40]), 64'(exp.l));
    checkOutput({tag, " left tail"},  64'(bits[39:32]), 64'd0);
    checkOutput({tag, " right"},      64'(bits[31:8]),  64'(exp.r));
    checkOutput({tag, " right tail"}, 64'(bits[7:0]),   64'd0);
    checkOutput({tag, " level"},      64'(fifo_level),  64'(expQ.size()));
    checkOutput({tag, " underrun"},   64'(underrun_count), 64'(underrunModel));
    checkOutput({tag, " small underrun"}, 64'(smallUnderrun), 64'(smallModel));
  endtask

  initial begin
    logic [63:0] bits;
    logic        b;

    vecs[0] = '{l: 24'h800001, r: 24'h000001, expLevel: 4'd1, expReady: 1'b1};
    vecs[1] = '{l: 24'hFFFFFF, r: 24'h000000, expLevel: 4'd2, expReady: 1'b1};
    vecs[2] = '{l: 24'h7FFFFF, r: 24'h800000, expLevel: 4'd3, expReady: 1'b1};
    vecs[3] = '{l: 24'h123456, r: 24'hABCDEF, expLevel: 4'd4, expReady: 1'b1};
    vecs[4] = '{l: 24'h000000, r: 24'hFFFFFF, expLevel: 4'd5, expReady: 1'b1};
    vecs[5] = '{l: 24'hC3C3C3, r: 24'h3C3C3C, expLevel: 4'd6, expReady: 1'b1};
    vecs[6] = '{l: 24'h0F0F0F, r: 24'hF0F0F0, expLevel: 4'd7, expReady: 1'b1};
    vecs[7] = '{l: 24'h555555, r: 24'hAAAAAA, expLevel: 4'd8, expReady: 1'b0};

    reset                = 1'b1;
    bus.write            = 1'b0;
    bus.writedata_left   = '0;
    bus.writedata_right  = '0;
    bus2.write           = 1'b0;
    bus2.writedata_left  = '0;
    bus2.writedata_right = '0;
    AUD_BCLK             = 1'b1;
    AUD_DACLRCK          = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (4) @(negedge CLOCK_50);

    $display("[TB] reset state");
    checkOutput("reset write_ready", 64'(bus.write_ready), 64'd1);
    checkOutput("reset dacdat",      64'(AUD_DACDAT),      64'd0);
    checkOutput("reset level",       64'(fifo_level),      64'd0);
    checkOutput("reset underrun",    64'(underrun_count),  64'd0);
    checkOutput("reset small ready", 64'(bus2.write_ready), 64'd1);

    $display("[TB] single pair");
    applyStimulus(24'hA5A5A5, 24'h5A5A5A);
    checkOutput("single level", 64'(fifo_level), 64'd1);
    playFrame(1'b0, '0, '0, "single", bits);

    $display("[TB] fill FIFO");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].l, vecs[i].r);
      checkOutput($sformatf("fill level %0d", i), 64'(fifo_level), 64'(vecs[i].expLevel));
      checkOutput($sformatf("fill ready %0d", i), 64'(bus.write_ready), 64'(vecs[i].expReady));
    end
    applyStimulus(24'hDEADBE, 24'hEFBEAD);
    checkOutput("overfill level", 64'(fifo_level),      64'd8);
    checkOutput("overfill ready", 64'(bus.write_ready), 64'd0);
    for (int i = 0; i < 8; i++) begin
      playFrame(1'b0, '0, '0, $sformatf("drain %0d", i), bits);
      if (i == 0) begin
        checkOutput("coincident first bit", 64'(bits[63]), 64'd1);
        checkOutput("coincident 24th bit",  64'(bits[40]), 64'd1);
      end
    end

    $display("[TB] underrun frames");
    for (int i = 0; i < 3; i++) begin
      playFrame(1'b0, '0, '0, $sformatf("empty %0d", i), bits);
    end
    checkOutput("underrun total", 64'(underrun_count), 64'd3);
    checkOutput("small saturated", 64'(smallUnderrun), 64'd3);

    $display("[TB] push on frame start");
    playFrame(1'b1, 24'h13579B, 24'h2468AC, "push at rise", bits);
    playFrame(1'b0, '0, '0, "after push at rise", bits);

    $display("[TB] reset mid-word");
    applyStimulus(24'hFFFFFF, 24'hFFFFFF);
    for (int s = 0; s < 5; s++) begin
      bclkSlot(1'b1, 1'b0, '0, '0, b);
    end
    void'(expQ.pop_front());
    checkOutput("pre-reset dacdat", 64'(AUD_DACDAT), 64'd1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("reset dacdat immediate", 64'(AUD_DACDAT), 64'd0);
    @(negedge CLOCK_50);
    expQ.delete();
    underrunModel = 0;
    smallModel    = 0;
    reset = 1'b0;
    applyStimulus(24'h0F1E2D, 24'h3C4B5A);
    bits = '0;
    for (int s = 5; s < 64; s++) begin
      bclkSlot(s < 32, 1'b0, '0, '0, b);
      bits[63-s] = b;
    end
    checkOutput("aborted frame bits",   bits, 64'd0);
    checkOutput("no spurious pop",      64'(fifo_level),     64'd1);
    checkOutput("post-reset underrun",  64'(underrun_count), 64'd0);
    checkOutput("post-reset small",     64'(smallUnderrun),  64'd0);
    playFrame(1'b0, '0, '0, "first after reset", bits);

    checkOutput("small level",  64'(smallLevel),  64'd0);
    checkOutput("small dacdat", 64'(smallDacdat), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
